// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback select unit.
// Optional memory load-size extension is enabled with macro WB_LOADSIZE_EN.
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_COMMIT   = 2'd2
  } wb_state_t;

  // load_size encodings; 2'b11 behaves like a word access
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_NUM_SRC     = 9;
  localparam int DEF_MEM_SRC     = 2;
  localparam int DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/wb_load_ext.sv
// Combinational sign extension of memory load data by access size.
// Only instantiated when WB_LOADSIZE_EN is defined.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        load_size,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = data_in;
    case (load_size)
      LS_WORD: data_out = data_in;
      LS_HALF: data_out = {{(DATA_W-16){data_in[15]}}, data_in[15:0]};
      LS_BYTE: data_out = {{(DATA_W-8){data_in[7]}}, data_in[7:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/wb_select_unit.sv
// Writeback source select with memory handshake, timeout and register-file strobe.
// Define WB_LOADSIZE_EN to sign-extend half/byte memory loads.
module wb_select_unit
  import wb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_SRC     = DEF_NUM_SRC,
  parameter int MEM_SRC     = DEF_MEM_SRC,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int SEL_W       = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_bus,
  input  logic [SEL_W-1:0]          sel,
  input  logic [4:0]                dst_addr,
  input  logic                      wb_req,
  input  logic                      mem_valid,
  input  logic [1:0]                load_size,
  output logic [DATA_W-1:0]         wb_data,
  output logic [4:0]                wb_addr,
  output logic                      wb_we,
  output logic                      busy,
  output logic                      sel_err
);

  localparam int                CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(MEM_TIMEOUT);
  localparam logic [SEL_W:0]    NUM_SRC_V = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0]  MEM_SEL   = SEL_W'(MEM_SRC);

  wb_state_t         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic [4:0]        dst_reg, dst_next;
  logic [1:0]        ls_reg, ls_next;
  logic              oor_reg, oor_next;
  logic              to_err_reg, to_err_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [4:0]        addr_reg, addr_next;

  logic [DATA_W-1:0] src_arr [NUM_SRC];
  logic [DATA_W-1:0] src_sel;
  logic [DATA_W-1:0] mem_data;
  logic              in_range;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign src_arr[gi] = src_bus[gi*DATA_W +: DATA_W];
  end

  assign in_range = ({1'b0, sel} < NUM_SRC_V);

  always_comb begin
    src_sel = '0;
    if (in_range) src_sel = src_arr[sel];
  end

`ifdef WB_LOADSIZE_EN
  wb_load_ext #(
    .DATA_W   (DATA_W)
  ) u_load_ext (
    .data_in  (src_arr[MEM_SRC]),
    .load_size(ls_reg),
    .data_out (mem_data)
  );
`else
  logic unused_ls;
  assign unused_ls = ^ls_reg;
  assign mem_data  = src_arr[MEM_SRC];
`endif

  assign cnt_inc = cnt_reg + CNT_W'(1);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    dst_next    = dst_reg;
    ls_next     = ls_reg;
    oor_next    = oor_reg;
    data_next   = data_reg;
    addr_next   = addr_reg;
    to_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (wb_req) begin
          dst_next = dst_addr;
          ls_next  = load_size;
          oor_next = !in_range;
          cnt_next = '0;
          if (sel == MEM_SEL) begin
            state_next = ST_WAIT_MEM;
          end else begin
            data_next  = src_sel;
            addr_next  = dst_addr;
            state_next = ST_COMMIT;
          end
        end
      end
      ST_WAIT_MEM: begin
        // mem_valid wins over a timeout landing on the same edge
        if (mem_valid) begin
          data_next  = mem_data;
          addr_next  = dst_reg;
          cnt_next   = '0;
          state_next = ST_COMMIT;
        end else if (cnt_inc == TIMEOUT_V) begin
          to_err_next = 1'b1;
          cnt_next    = '0;
          state_next  = ST_IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ST_COMMIT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      dst_reg    <= '0;
      ls_reg     <= '0;
      oor_reg    <= 1'b0;
      to_err_reg <= 1'b0;
      data_reg   <= '0;
      addr_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      dst_reg    <= dst_next;
      ls_reg     <= ls_next;
      oor_reg    <= oor_next;
      to_err_reg <= to_err_next;
      data_reg   <= data_next;
      addr_reg   <= addr_next;
    end
  end

  // Writes to register 0 run the whole sequence but never strobe
  assign wb_we   = (state_reg == ST_COMMIT) && (dst_reg != 5'd0);
  assign busy    = (state_reg != ST_IDLE);
  assign sel_err = to_err_reg | ((state_reg == ST_COMMIT) && oor_reg);
  assign wb_data = data_reg;
  assign wb_addr = addr_reg;

endmodule

// File: tb/tb_wb_select_unit.sv
// Directed self-checking bench for wb_select_unit.
// Expected memory data depends on whether WB_LOADSIZE_EN is defined.
module tb_wb_select_unit;

  localparam int DW = 32;
  localparam int NS = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic [NS*DW-1:0] src_bus;
  logic [3:0]      sel;
  logic [4:0]      dst_addr;
  logic            wb_req;
  logic            mem_valid;
  logic [1:0]      load_size;
  logic [DW-1:0]   wb_data;
  logic [4:0]      wb_addr;
  logic            wb_we;
  logic            busy;
  logic            sel_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_select_unit dut (
    .clk      (clk),
    .reset    (reset),
    .src_bus  (src_bus),
    .sel      (sel),
    .dst_addr (dst_addr),
    .wb_req   (wb_req),
    .mem_valid(mem_valid),
    .load_size(load_size),
    .wb_data  (wb_data),
    .wb_addr  (wb_addr),
    .wb_we    (wb_we),
    .busy     (busy),
    .sel_err  (sel_err)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_src(input int k, input logic [DW-1:0] v);
    src_bus[k*DW +: DW] = v;
  endtask

  task automatic request(input logic [3:0] s, input logic [4:0] d, input logic [1:0] ls);
    sel = s; dst_addr = d; load_size = ls; wb_req = 1'b1;
    tick();
    wb_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    total++;
    if ({wb_data, wb_addr, wb_we, busy, sel_err} !== {32'h0, 5'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_state: got data=%h addr=%0d we=%b busy=%b err=%b required all 0",
               wb_data, wb_addr, wb_we, busy, sel_err);
    end
    reset = 1'b1;
    tick();
    $display("txn reset: outputs cleared");
  endtask

  task automatic test_nonmem(input logic [3:0] s, input logic [4:0] d, input logic [DW-1:0] exp);
    request(s, d, 2'b00);
    total++;
    if ({wb_we, busy, sel_err, wb_data, wb_addr} !== {3'b110, exp, d}) begin
      bad++;
      $display("FAIL nonmem_commit sel=%0d: got we=%b busy=%b err=%b data=%h addr=%0d required we=1 busy=1 err=0 data=%h addr=%0d",
               s, wb_we, busy, sel_err, wb_data, wb_addr, exp, d);
    end
    tick();
    total++;
    if ({wb_we, busy, wb_data, wb_addr} !== {2'b00, exp, d}) begin
      bad++;
      $display("FAIL nonmem_after sel=%0d: got we=%b busy=%b data=%h addr=%0d required we=0 busy=0 data=%h addr=%0d",
               s, wb_we, busy, wb_data, wb_addr, exp, d);
    end
    $display("txn nonmem: sel=%0d dst=%0d data=%h", s, d, exp);
  endtask

  task automatic test_mem(input logic [1:0] ls, input logic [4:0] d, input int waits,
                          input logic [DW-1:0] raw, input logic [DW-1:0] exp);
    request(4'd2, d, ls);
    for (int i = 0; i < waits; i++) begin
      total++;
      if ({busy, wb_we, sel_err} !== 3'b100) begin
        bad++;
        $display("FAIL mem_wait cycle %0d: got busy=%b we=%b err=%b required 1 0 0", i, busy, wb_we, sel_err);
      end
      tick();
    end
    set_src(2, raw);
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    total++;
    if ({wb_we, sel_err, wb_data, wb_addr} !== {2'b10, exp, d}) begin
      bad++;
      $display("FAIL mem_commit ls=%b: got we=%b err=%b data=%h addr=%0d required we=1 err=0 data=%h addr=%0d",
               ls, wb_we, sel_err, wb_data, wb_addr, exp, d);
    end
    tick();
    total++;
    if ({wb_we, busy} !== 2'b00) begin
      bad++;
      $display("FAIL mem_after: got we=%b busy=%b required 0 0", wb_we, busy);
    end
    $display("txn mem: ls=%b dst=%0d raw=%h data=%h", ls, d, raw, exp);
  endtask

  task automatic test_timeout();
    logic [4:0] prev_addr;
    prev_addr = wb_addr;
    request(4'd2, 5'd4, 2'b00);
    for (int i = 1; i < 15; i++) begin
      tick();
      total++;
      if ({busy, wb_we, sel_err} !== 3'b100) begin
        bad++;
        $display("FAIL timeout_wait %0d: got busy=%b we=%b err=%b required 1 0 0", i, busy, wb_we, sel_err);
      end
    end
    tick();
    total++;
    if ({busy, wb_we, sel_err, wb_addr} !== {3'b001, prev_addr}) begin
      bad++;
      $display("FAIL timeout_err: got busy=%b we=%b err=%b addr=%0d required 0 0 1 addr=%0d",
               busy, wb_we, sel_err, wb_addr, prev_addr);
    end
    tick();
    total++;
    if ({busy, wb_we, sel_err} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_clear: got busy=%b we=%b err=%b required 0 0 0", busy, wb_we, sel_err);
    end
    $display("txn timeout: sel_err after 15 wait cycles");
  endtask

  task automatic test_oor(input logic [4:0] d, input logic exp_we);
    request(4'd12, d, 2'b00);
    total++;
    if ({busy, wb_we, sel_err, wb_data} !== {1'b1, exp_we, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL oor_commit dst=%0d: got busy=%b we=%b err=%b data=%h required 1 %b 1 data=0",
               d, busy, wb_we, sel_err, wb_data, exp_we);
    end
    tick();
    total++;
    if ({busy, wb_we, sel_err} !== 3'b000) begin
      bad++;
      $display("FAIL oor_after: got busy=%b we=%b err=%b required 0 0 0", busy, wb_we, sel_err);
    end
    $display("txn oor: sel=12 dst=%0d", d);
  endtask

  task automatic test_idle_mem_valid();
    mem_valid = 1'b1;
    tick(); tick();
    mem_valid = 1'b0;
    total++;
    if ({busy, wb_we, sel_err} !== 3'b000) begin
      bad++;
      $display("FAIL idle_mem_valid: got busy=%b we=%b err=%b required 0 0 0", busy, wb_we, sel_err);
    end
    $display("txn idle mem_valid ignored");
  endtask

  task automatic test_busy_ignore();
    request(4'd2, 5'd6, 2'b00);
    sel = 4'd3; dst_addr = 5'd8; wb_req = 1'b1;
    tick();
    wb_req = 1'b0;
    set_src(2, 32'h1234_5678);
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    total++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd6, 32'h1234_5678}) begin
      bad++;
      $display("FAIL busy_commit: got we=%b addr=%0d data=%h required we=1 addr=6 data=12345678",
               wb_we, wb_addr, wb_data);
    end
    tick();
    total++;
    if ({busy, wb_we} !== 2'b00) begin
      bad++;
      $display("FAIL busy_no_queue: got busy=%b we=%b required 0 0", busy, wb_we);
    end
    $display("txn busy: second request ignored");
  endtask

  task automatic test_reset_midflight();
    request(4'd2, 5'd9, 2'b00);
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({wb_data, wb_addr, wb_we, busy, sel_err} !== {32'h0, 5'd0, 3'b000}) begin
      bad++;
      $display("FAIL midflight_reset: got data=%h addr=%0d we=%b busy=%b err=%b required all 0",
               wb_data, wb_addr, wb_we, busy, sel_err);
    end
    reset = 1'b1;
    mem_valid = 1'b1;
    tick();
    mem_valid = 1'b0;
    tick();
    total++;
    if ({wb_we, busy, wb_data, wb_addr} !== {2'b00, 32'h0, 5'd0}) begin
      bad++;
      $display("FAIL midflight_no_write: got we=%b busy=%b data=%h addr=%0d required 0 0 0 0",
               wb_we, busy, wb_data, wb_addr);
    end
    $display("txn reset during WAIT_MEM discards write");
  endtask

  initial begin
    reset = 1'b0; wb_req = 1'b0; mem_valid = 1'b0;
    sel = '0; dst_addr = '0; load_size = '0;
    for (int k = 0; k < NS; k++) set_src(k, 32'hA000_0000 + 32'(k));
    set_src(3, 32'hDEAD_BEEF);

    test_reset();
    test_nonmem(4'd3, 5'd5, 32'hDEAD_BEEF);
    test_nonmem(4'd0, 5'd31, 32'hA000_0000);
    test_nonmem(4'd8, 5'd9, 32'hA000_0008);
    test_idle_mem_valid();
`ifdef WB_LOADSIZE_EN
    test_mem(2'b10, 5'd10, 3, 32'h0000_00F0, 32'hFFFF_FFF0);
    test_mem(2'b01, 5'd11, 1, 32'h0000_8001, 32'hFFFF_8001);
    test_mem(2'b10, 5'd12, 0, 32'hFFFF_FF70, 32'h0000_0070);
`else
    test_mem(2'b10, 5'd10, 3, 32'h0000_00F0, 32'h0000_00F0);
    test_mem(2'b01, 5'd11, 1, 32'h0000_8001, 32'h0000_8001);
    test_mem(2'b10, 5'd12, 0, 32'hFFFF_FF70, 32'hFFFF_FF70);
`endif
    test_mem(2'b00, 5'd13, 14, 32'h8000_0080, 32'h8000_0080);
    test_timeout();
    test_oor(5'd7, 1'b1);
    test_oor(5'd0, 1'b0);
    test_busy_ignore();
    test_reset_midflight();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
